jar_sram_burst: RTL and testbench
=================================

Name: jar_sram_burst

Overview:
- Parametrised successor to the team's nibble-serial scratch SRAM for narrow-pin tiles.
- Data is shifted in NW bits at a time into a holding register, then committed to a DEPTH-entry memory.
- Supports single-address read/write, auto-incrementing burst read and burst write through a shared pointer, and a status readback.
- Sits directly behind the tile's input pins; output is gated by output-enable.

Parameters:
- DW, 8, data word width; must be a multiple of NW.
- NW, 4, width of the shared address/data input bus; must satisfy NW >= AW.
- AW, 3, address width.
- DEPTH, 8, number of words; 2 <= DEPTH <= 2**AW.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- we  input  1  write enable.
- oe  input  1  output enable.
- commit  input  1  commit / pointer control.
- addr_data  input  NW  shared address or data nibble; address = addr_data[AW-1:0].
- io_out  output  DW  holding register when oe=1, else all zeros.
- word_ready  output  1  high when DW/NW nibbles have been shifted in since the last clear.
- wrapped  output  1  sticky flag; burst pointer has wrapped DEPTH-1 -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous): holding register data_tmp=0, ptr=0, nib_cnt=0, wrapped=0, all mem words=0. Outputs io_out=0, word_ready=0, wrapped=0. Deassertion takes effect at the next clk edge. Reset mid-burst abandons the burst with no partial write.
- Operation per rising edge is decoded from {we,oe,commit}, with exactly one action per cycle:
  - 111 PTR_SET: ptr <= addr; wrapped <= 0.
  - 110 BURST_RD: data_tmp <= mem[ptr]; ptr advances.
  - 101 BURST_WR: mem[ptr] <= data_tmp; ptr advances; nib_cnt <= 0.
  - 100 SHIFT: data_tmp <= {addr_data, data_tmp[DW-1:NW]}, low nibble first; nib_cnt <= min(nib_cnt+1, DW/NW).
  - 011 STATUS: data_tmp <= zero-extended {wrapped, nib_cnt, ptr} (ptr in LSBs); no other state changes.
  - 010 READ: data_tmp <= (addr < DEPTH) ? mem[addr] : 0; nib_cnt <= 0.
  - 001 WRITE: if addr < DEPTH then mem[addr] <= data_tmp; out-of-range is a no-op for mem; nib_cnt <= 0 in both cases.
  - 000 IDLE: hold all state.
- Pointer advance: if ptr == DEPTH-1 then ptr <= 0 and wrapped <= 1 (sticky until PTR_SET or reset); otherwise ptr <= ptr+1. This must hold for non-power-of-two DEPTH.
- PTR_SET with addr >= DEPTH loads ptr <= 0.
- Burst read latency: the word at ptr appears on io_out one edge after the BURST_RD cycle, provided oe stays high.
- Burst write commits whatever is in data_tmp. It does not require word_ready; the writer is responsible.
- word_ready = (nib_cnt == DW/NW). Further shifts keep it high and overwrite the oldest nibbles.
- io_out is combinational: oe ? data_tmp : 0. No registered output stage.
- mem read and write are synchronous. BURST_RD and BURST_WR never occur in the same cycle, so there is no read/write collision.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> io_out=0, word_ready=0, wrapped=0 immediately; after release, READ of every address -> 0x00.
- Shift/write/read (DW=8, NW=4): SHIFT 0x5 then 0xA -> word_ready=1; WRITE addr 3 -> word_ready=0; READ addr 3 with oe=1 -> io_out=0xA5.
- Burst write: PTR_SET 6; load 0x11, BURST_WR; load 0x22, BURST_WR; load 0x33, BURST_WR -> mem[6]=0x11, mem[7]=0x22, mem[0]=0x33, wrapped=1, ptr=1.
- Burst read: after the previous test, PTR_SET 6 (wrapped clears), three BURST_RD -> io_out=0x11, 0x22, 0x33 on successive edges; wrapped=1 after the third.
- Non-power-of-two, DEPTH=5: PTR_SET 4; BURST_WR -> ptr=0, wrapped=1. WRITE addr 6 -> no memory change. READ addr 6 -> io_out=0x00.
- Status/idle: SHIFT once, then STATUS with ptr=2 -> io_out = {wrapped=0, nib_cnt=1, ptr=2} = 0x0A for AW=3. Then {we,oe,commit}=000 for 4 cycles -> all state unchanged; io_out=0 while oe=0.

Source files
------------

// File: rtl/jar_sram_burst_if.sv
// Pin-side bus of the burst scratch SRAM: control strobes, shared
// address/data nibble bus, and the gated data/status outputs.
interface jar_sram_burst_if #(
  parameter int DW = 8,
  parameter int NW = 4
);
  logic          we;
  logic          oe;
  logic          commit;
  logic [NW-1:0] addr_data;
  logic [DW-1:0] io_out;
  logic          word_ready;
  logic          wrapped;

  // Tile-side driver of the pins
  modport master (
    output we, oe, commit, addr_data,
    input  io_out, word_ready, wrapped
  );

  // The SRAM block itself
  modport slave (
    input  we, oe, commit, addr_data,
    output io_out, word_ready, wrapped
  );
endinterface

// File: rtl/jar_sram_burst.sv
// Nibble-serial scratch SRAM with a shared auto-incrementing burst pointer.
// Words are assembled NW bits at a time in a holding register (low nibble
// first) and committed to / loaded from a DEPTH-entry register file. One
// action per clock, selected by {we,oe,commit}.
module jar_sram_burst #(
  parameter int DW    = 8,
  parameter int NW    = 4,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  jar_sram_burst_if.slave bus
);

  localparam int NPW = DW / NW;              // nibbles per word
  localparam int CW  = $clog2(NPW + 1);      // nib_cnt must reach NPW
  localparam int SW  = 1 + CW + AW;          // status word width

  localparam logic [2:0] OP_PTR_SET  = 3'b111;
  localparam logic [2:0] OP_BURST_RD = 3'b110;
  localparam logic [2:0] OP_BURST_WR = 3'b101;
  localparam logic [2:0] OP_SHIFT    = 3'b100;
  localparam logic [2:0] OP_STATUS   = 3'b011;
  localparam logic [2:0] OP_READ     = 3'b010;
  localparam logic [2:0] OP_WRITE    = 3'b001;

  logic [DW-1:0] data_tmp_q, data_tmp_d;
  logic [AW-1:0] ptr_q,      ptr_d;
  logic [CW-1:0] nib_cnt_q,  nib_cnt_d;
  logic          wrapped_q,  wrapped_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic          ptr_last;
  logic [AW-1:0] ptr_adv;
  logic [SW-1:0] status_word;

  assign op       = {bus.we, bus.oe, bus.commit};
  assign addr     = bus.addr_data[AW-1:0];
  // Widened compare so it stays meaningful when DEPTH == 2**AW
  assign addr_ok  = ({1'b0, addr} < (AW+1)'(DEPTH));
  // Wrap on DEPTH-1 explicitly so non-power-of-two depths never run past the end
  assign ptr_last = (ptr_q == AW'(DEPTH - 1));
  assign ptr_adv  = ptr_last ? '0 : ptr_q + 1'b1;
  assign status_word = {wrapped_q, nib_cnt_q, ptr_q};

  // Next-state decode: exactly one action per cycle
  always_comb begin
    data_tmp_d = data_tmp_q;
    ptr_d      = ptr_q;
    nib_cnt_d  = nib_cnt_q;
    wrapped_d  = wrapped_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    case (op)
      OP_PTR_SET: begin
        ptr_d     = addr_ok ? addr : '0;
        wrapped_d = 1'b0;
      end
      OP_BURST_RD: begin
        data_tmp_d = mem_q[ptr_q];
        ptr_d      = ptr_adv;
        wrapped_d  = wrapped_q | ptr_last;
      end
      OP_BURST_WR: begin
        mem_d[ptr_q] = data_tmp_q;
        ptr_d        = ptr_adv;
        wrapped_d    = wrapped_q | ptr_last;
        nib_cnt_d    = '0;
      end
      OP_SHIFT: begin
        // New nibble enters at the top so the first one shifted ends up lowest;
        // shift form also covers the DW == NW case without an empty slice
        data_tmp_d = (data_tmp_q >> NW) | (DW'(bus.addr_data) << (DW - NW));
        nib_cnt_d  = (nib_cnt_q == CW'(NPW)) ? nib_cnt_q : nib_cnt_q + 1'b1;
      end
      OP_STATUS: begin
        data_tmp_d = DW'(status_word);
      end
      OP_READ: begin
        data_tmp_d = addr_ok ? mem_q[addr] : '0;
        nib_cnt_d  = '0;
      end
      OP_WRITE: begin
        if (addr_ok) begin
          mem_d[addr] = data_tmp_q;
        end
        nib_cnt_d = '0;
      end
      default: begin
        // idle: hold everything
      end
    endcase
  end

  // Control/holding state, cleared asynchronously so a burst in flight is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_tmp_q <= '0;
      ptr_q      <= '0;
      nib_cnt_q  <= '0;
      wrapped_q  <= 1'b0;
    end else begin
      data_tmp_q <= data_tmp_d;
      ptr_q      <= ptr_d;
      nib_cnt_q  <= nib_cnt_d;
      wrapped_q  <= wrapped_d;
    end
  end

  // Storage array; cleared on reset, so it is built from flops rather than RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.io_out     = bus.oe ? data_tmp_q : '0;
  assign bus.word_ready = (nib_cnt_q == CW'(NPW));
  assign bus.wrapped    = wrapped_q;

endmodule

// File: tb/tb_jar_sram_burst.sv
// Self-checking bench for jar_sram_burst: one DUT at DEPTH=8 and one at
// DEPTH=5, expected read data queued when a read is issued and checked
// when it appears on io_out.
module tb_jar_sram_burst;

  localparam logic [2:0] C_PTR_SET  = 3'b111;
  localparam logic [2:0] C_BURST_RD = 3'b110;
  localparam logic [2:0] C_BURST_WR = 3'b101;
  localparam logic [2:0] C_SHIFT    = 3'b100;
  localparam logic [2:0] C_STATUS   = 3'b011;
  localparam logic [2:0] C_READ     = 3'b010;
  localparam logic [2:0] C_WRITE    = 3'b001;
  localparam logic [2:0] C_IDLE     = 3'b000;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;
  logic [7:0] sb [$];
  logic [7:0] exp_v;

  jar_sram_burst_if #(.DW(8), .NW(4)) b8 ();
  jar_sram_burst_if #(.DW(8), .NW(4)) b5 ();

  jar_sram_burst #(.DW(8), .NW(4), .AW(3), .DEPTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  jar_sram_burst #(.DW(8), .NW(4), .AW(3), .DEPTH(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One operation on the DEPTH=8 instance; returns 1 ns after the edge
  task automatic op8(input logic [2:0] c, input logic [3:0] ad);
    {b8.we, b8.oe, b8.commit} = c;
    b8.addr_data = ad;
    @(posedge clk);
    #1;
    $display("dut8 op=%b ad=%h -> io_out=%h word_ready=%b wrapped=%b",
             c, ad, b8.io_out, b8.word_ready, b8.wrapped);
  endtask

  // One operation on the DEPTH=5 instance
  task automatic op5(input logic [2:0] c, input logic [3:0] ad);
    {b5.we, b5.oe, b5.commit} = c;
    b5.addr_data = ad;
    @(posedge clk);
    #1;
    $display("dut5 op=%b ad=%h -> io_out=%h word_ready=%b wrapped=%b",
             c, ad, b5.io_out, b5.word_ready, b5.wrapped);
  endtask

  task automatic test_reset;
    op8(C_SHIFT, 4'hF);
    op8(C_SHIFT, 4'hF);
    op8(C_PTR_SET, 4'h7);
    op8(C_BURST_WR, 4'h0);   // mem[7]=FF, ptr wraps to 0
    op8(C_SHIFT, 4'h1);
    op8(C_SHIFT, 4'h2);
    op8(C_STATUS, 4'h0);     // {1, 2, 0} = 0x30
    n_vec++;
    if (b8.io_out !== 8'h30) begin
      n_err++;
      $display("FAIL pre_reset_status io_out=%h expected=%h", b8.io_out, 8'h30);
    end
    n_vec++;
    if (b8.word_ready !== 1'b1 || b8.wrapped !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_flags word_ready=%b wrapped=%b expected=1 1",
               b8.word_ready, b8.wrapped);
    end
    // Async assertion mid-cycle with oe still high
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (b8.io_out !== 8'h00 || b8.word_ready !== 1'b0 || b8.wrapped !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset io_out=%h word_ready=%b wrapped=%b expected=00 0 0",
               b8.io_out, b8.word_ready, b8.wrapped);
    end
    {b8.we, b8.oe, b8.commit} = C_IDLE;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      sb.push_back(8'h00);
      op8(C_READ, 4'(a));
      exp_v = sb.pop_front();
      n_vec++;
      if (b8.io_out !== exp_v) begin
        n_err++;
        $display("FAIL reset_mem_read addr=%0d io_out=%h expected=%h", a, b8.io_out, exp_v);
      end
    end
  endtask

  task automatic test_shift_write_read;
    op8(C_SHIFT, 4'h5);
    n_vec++;
    if (b8.word_ready !== 1'b0) begin
      n_err++;
      $display("FAIL half_word_ready word_ready=%b expected=0", b8.word_ready);
    end
    op8(C_SHIFT, 4'hA);
    n_vec++;
    if (b8.word_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_word_ready word_ready=%b expected=1", b8.word_ready);
    end
    op8(C_WRITE, 4'h3);
    n_vec++;
    if (b8.word_ready !== 1'b0) begin
      n_err++;
      $display("FAIL write_clears_ready word_ready=%b expected=0", b8.word_ready);
    end
    sb.push_back(8'hA5);
    op8(C_READ, 4'h3);
    exp_v = sb.pop_front();
    n_vec++;
    if (b8.io_out !== exp_v) begin
      n_err++;
      $display("FAIL read_addr3 io_out=%h expected=%h", b8.io_out, exp_v);
    end
  endtask

  task automatic test_burst_write;
    op8(C_PTR_SET, 4'h6);
    op8(C_SHIFT, 4'h1);
    op8(C_SHIFT, 4'h1);
    op8(C_BURST_WR, 4'h0);
    n_vec++;
    if (b8.wrapped !== 1'b0) begin
      n_err++;
      $display("FAIL bwr_first_wrapped wrapped=%b expected=0", b8.wrapped);
    end
    op8(C_SHIFT, 4'h2);
    op8(C_SHIFT, 4'h2);
    op8(C_BURST_WR, 4'h0);
    op8(C_SHIFT, 4'h3);
    op8(C_SHIFT, 4'h3);
    op8(C_BURST_WR, 4'h0);
    n_vec++;
    if (b8.wrapped !== 1'b1) begin
      n_err++;
      $display("FAIL bwr_wrapped wrapped=%b expected=1", b8.wrapped);
    end
    op8(C_STATUS, 4'h0);     // {1, 0, ptr=1} = 0x21
    n_vec++;
    if (b8.io_out !== 8'h21) begin
      n_err++;
      $display("FAIL bwr_status io_out=%h expected=%h", b8.io_out, 8'h21);
    end
    sb.push_back(8'h11); op8(C_READ, 4'h6);
    exp_v = sb.pop_front();
    n_vec++;
    if (b8.io_out !== exp_v) begin
      n_err++;
      $display("FAIL bwr_mem6 io_out=%h expected=%h", b8.io_out, exp_v);
    end
    sb.push_back(8'h22); op8(C_READ, 4'h7);
    exp_v = sb.pop_front();
    n_vec++;
    if (b8.io_out !== exp_v) begin
      n_err++;
      $display("FAIL bwr_mem7 io_out=%h expected=%h", b8.io_out, exp_v);
    end
    sb.push_back(8'h33); op8(C_READ, 4'h0);
    exp_v = sb.pop_front();
    n_vec++;
    if (b8.io_out !== exp_v) begin
      n_err++;
      $display("FAIL bwr_mem0 io_out=%h expected=%h", b8.io_out, exp_v);
    end
  endtask

  task automatic test_burst_read;
    op8(C_PTR_SET, 4'h6);
    n_vec++;
    if (b8.wrapped !== 1'b0) begin
      n_err++;
      $display("FAIL ptr_set_clears_wrapped wrapped=%b expected=0", b8.wrapped);
    end
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    for (int k = 0; k < 3; k++) begin
      op8(C_BURST_RD, 4'h0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL brd_scoreboard_empty beat=%0d io_out=%h expected=queued", k, b8.io_out);
      end else begin
        exp_v = sb.pop_front();
        n_vec++;
        if (b8.io_out !== exp_v) begin
          n_err++;
          $display("FAIL brd_beat%0d io_out=%h expected=%h", k, b8.io_out, exp_v);
        end
      end
      if (k == 0) begin
        n_vec++;
        if (b8.wrapped !== 1'b0) begin
          n_err++;
          $display("FAIL brd_early_wrapped wrapped=%b expected=0", b8.wrapped);
        end
      end
    end
    n_vec++;
    if (b8.wrapped !== 1'b1) begin
      n_err++;
      $display("FAIL brd_wrapped wrapped=%b expected=1", b8.wrapped);
    end
  endtask

  task automatic test_non_pow2;
    op5(C_PTR_SET, 4'h4);
    op5(C_SHIFT, 4'h9);
    op5(C_SHIFT, 4'h9);
    op5(C_BURST_WR, 4'h0);
    n_vec++;
    if (b5.wrapped !== 1'b1) begin
      n_err++;
      $display("FAIL d5_wrapped wrapped=%b expected=1", b5.wrapped);
    end
    op5(C_STATUS, 4'h0);     // {1, 0, ptr=0} = 0x20
    n_vec++;
    if (b5.io_out !== 8'h20) begin
      n_err++;
      $display("FAIL d5_status io_out=%h expected=%h", b5.io_out, 8'h20);
    end
    op5(C_SHIFT, 4'h7);
    op5(C_SHIFT, 4'h7);
    op5(C_WRITE, 4'h6);      // out of range: memory untouched
    for (int a = 0; a < 5; a++) begin
      sb.push_back((a == 4) ? 8'h99 : 8'h00);
      op5(C_READ, 4'(a));
      exp_v = sb.pop_front();
      n_vec++;
      if (b5.io_out !== exp_v) begin
        n_err++;
        $display("FAIL d5_mem_read addr=%0d io_out=%h expected=%h", a, b5.io_out, exp_v);
      end
    end
    sb.push_back(8'h00);
    op5(C_READ, 4'h6);
    exp_v = sb.pop_front();
    n_vec++;
    if (b5.io_out !== exp_v) begin
      n_err++;
      $display("FAIL d5_read_oor io_out=%h expected=%h", b5.io_out, exp_v);
    end
    op5(C_PTR_SET, 4'h2);
    op5(C_STATUS, 4'h0);
    n_vec++;
    if (b5.io_out !== 8'h02) begin
      n_err++;
      $display("FAIL d5_ptr_set2 io_out=%h expected=%h", b5.io_out, 8'h02);
    end
    op5(C_PTR_SET, 4'h6);
    op5(C_STATUS, 4'h0);
    n_vec++;
    if (b5.io_out !== 8'h00) begin
      n_err++;
      $display("FAIL d5_ptr_set_oor io_out=%h expected=%h", b5.io_out, 8'h00);
    end
  endtask

  task automatic test_status_idle;
    sb.push_back(8'h33);
    op8(C_READ, 4'h0);       // also clears nib_cnt
    exp_v = sb.pop_front();
    n_vec++;
    if (b8.io_out !== exp_v) begin
      n_err++;
      $display("FAIL si_read0 io_out=%h expected=%h", b8.io_out, exp_v);
    end
    op8(C_PTR_SET, 4'h2);
    op8(C_SHIFT, 4'hC);
    op8(C_STATUS, 4'h0);     // {0, 1, 2} = 0x0A
    n_vec++;
    if (b8.io_out !== 8'h0A) begin
      n_err++;
      $display("FAIL si_status io_out=%h expected=%h", b8.io_out, 8'h0A);
    end
    for (int k = 0; k < 4; k++) begin
      op8(C_IDLE, 4'hF);
      n_vec++;
      if (b8.io_out !== 8'h00 || b8.word_ready !== 1'b0 || b8.wrapped !== 1'b0) begin
        n_err++;
        $display("FAIL si_idle%0d io_out=%h word_ready=%b wrapped=%b expected=00 0 0",
                 k, b8.io_out, b8.word_ready, b8.wrapped);
      end
    end
    op8(C_STATUS, 4'h0);
    n_vec++;
    if (b8.io_out !== 8'h0A) begin
      n_err++;
      $display("FAIL si_status_after_idle io_out=%h expected=%h", b8.io_out, 8'h0A);
    end
  endtask

  task automatic test_back_to_back;
    op8(C_SHIFT, 4'h1);
    op8(C_SHIFT, 4'h2);
    op8(C_SHIFT, 4'h3);      // oldest nibble dropped: 0x32
    n_vec++;
    if (b8.word_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_saturated_ready word_ready=%b expected=1", b8.word_ready);
    end
    op8(C_WRITE, 4'h5);
    sb.push_back(8'h32);
    sb.push_back(8'hA5);
    op8(C_READ, 4'h5);
    exp_v = sb.pop_front();
    n_vec++;
    if (b8.io_out !== exp_v) begin
      n_err++;
      $display("FAIL b2b_read5 io_out=%h expected=%h", b8.io_out, exp_v);
    end
    op8(C_READ, 4'h3);
    exp_v = sb.pop_front();
    n_vec++;
    if (b8.io_out !== exp_v) begin
      n_err++;
      $display("FAIL b2b_read3 io_out=%h expected=%h", b8.io_out, exp_v);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    {b8.we, b8.oe, b8.commit} = C_IDLE;
    {b5.we, b5.oe, b5.commit} = C_IDLE;
    b8.addr_data = 4'h0;
    b5.addr_data = 4'h0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    test_reset();
    test_shift_write_read();
    test_burst_write();
    test_burst_read();
    test_non_pow2();
    test_status_idle();
    test_back_to_back();

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover entries=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
